// File: rtl/ntt_butterfly_addsub_if.sv
// Butterfly back-end bus: operand/product inputs and result outputs.
// Master drives a/p, slave returns x/y and the alignment flag.
interface ntt_bf_if #(
  parameter int DW = 30
);
  logic          in_valid;
  logic [DW-1:0] a_in;
  logic          prod_valid;
  logic [DW-1:0] p_in;
  logic          out_valid;
  logic [DW-1:0] x_out;
  logic [DW-1:0] y_out;
  logic          align_err;

  modport master (
    output in_valid, a_in, prod_valid, p_in,
    input  out_valid, x_out, y_out, align_err
  );

  modport slave (
    input  in_valid, a_in, prod_valid, p_in,
    output out_valid, x_out, y_out, align_err
  );
endinterface

// File: rtl/ntt_butterfly_addsub.sv
// NTT Cooley-Tukey butterfly add/sub back end.
// x = (a + p) mod q, y = (a - p) mod q, a delayed to meet the product.
module ntt_butterfly_addsub #(
  parameter int Q_INDEX = 0,
  parameter int A_DELAY = 4,
  parameter int DW      = 30
) (
  input logic   clk,
  input logic   rst_n,
  ntt_bf_if.slave bus
);

  localparam logic [DW-1:0] Q =
    (Q_INDEX == 8)  ? DW'(1069219841) :
    (Q_INDEX == 12) ? DW'(1073479681) :
                      DW'(1063321601);

  if (Q_INDEX != 0 && Q_INDEX != 8 && Q_INDEX != 12) begin : g_bad_q
    $error("ntt_butterfly_addsub: illegal Q_INDEX %0d", Q_INDEX);
  end

  if (A_DELAY < 1 || A_DELAY > 16) begin : g_bad_d
    $error("ntt_butterfly_addsub: illegal A_DELAY %0d", A_DELAY);
  end

  logic [A_DELAY-1:0]         r_dv;
  logic [A_DELAY-1:0][DW-1:0] r_da;
  logic                       w_vd;
  logic [DW-1:0]              w_ad;
  logic                       w_go;

  logic          r_v1;
  logic [DW:0]   r_s;
  logic [DW:0]   r_d;
  logic [DW-1:0] w_x;
  logic [DW-1:0] w_y;

  logic          r_ov;
  logic [DW-1:0] r_x;
  logic [DW-1:0] r_y;
  logic          r_ae;

  assign w_vd = r_dv[A_DELAY-1];
  assign w_ad = r_da[A_DELAY-1];
  assign w_go = w_vd & bus.prod_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dv <= '0;
      r_da <= '0;
    end else begin
      r_dv[0] <= bus.in_valid;
      r_da[0] <= bus.a_in;
      for (int i = 1; i < A_DELAY; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_da[i] <= r_da[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_s  <= '0;
      r_d  <= '0;
    end else begin
      r_v1 <= w_go;
      if (w_go) begin
        r_s <= {1'b0, w_ad} + {1'b0, bus.p_in};
        r_d <= {1'b0, w_ad} - {1'b0, bus.p_in};
      end
    end
  end

  // Single conditional correction; top bits are dropped on purpose.
  assign w_x = (r_s >= {1'b0, Q}) ? r_s[DW-1:0] - Q
                                  : r_s[DW-1:0];
  assign w_y = r_d[DW] ? r_d[DW-1:0] + Q
                       : r_d[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov <= 1'b0;
      r_x  <= '0;
      r_y  <= '0;
    end else begin
      r_ov <= r_v1;
      if (r_v1) begin
        r_x <= w_x;
        r_y <= w_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ae <= 1'b0;
    end else if (w_vd != bus.prod_valid) begin
      r_ae <= 1'b1;
    end
  end

  assign bus.out_valid = r_ov;
  assign bus.x_out     = r_x;
  assign bus.y_out     = r_y;
  assign bus.align_err = r_ae;

endmodule

// File: doc/ntt_butterfly_addsub.md
Name: ntt_butterfly_addsub

Overview:
- Cooley-Tukey butterfly back end, directly downstream of modular_multiplier in the NTT datapath.
- Takes upper operand a and the twiddle product p = w*b mod q, which the multiplier computes from the lower operand.
- Produces x = (a + p) mod q and y = (a - p) mod q, fully pipelined at one butterfly per cycle.
- Internally delays a so it lines up with the multiplier's product.

Parameters:
- Q_INDEX, 0, modulus select; must match the paired multiplier's parameter. 0 -> q=1063321601, 8 -> q=1069219841, 12 -> q=1073479681. Any other value is illegal: simulation $error at elaboration.
- A_DELAY, 4, cycles a_in is delayed before use; equals paired multiplier latency; legal range 1..16.
- DW, 30, coefficient width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a_in valid; asserted in the same cycle the pair (a, b) enters the multiplier.
- a_in  in  DW  upper operand, must be < q.
- prod_valid  in  1  p_in valid, driven by the multiplier-side valid pipeline.
- p_in  in  DW  product w*b mod q, must be < q.
- out_valid  out  1  x_out/y_out valid.
- x_out  out  DW  (a + p) mod q.
- y_out  out  DW  (a - p) mod q.
- align_err  out  1  sticky alignment error flag.

Behaviour:
- Reset (rst_n low, asynchronous): all delay-line entries, valid bits, pipeline registers, out_valid, x_out, y_out and align_err go to 0 immediately.
- Reset mid-operation drops every in-flight butterfly. After release, no output appears until new in_valid data has traversed the full pipeline.
- Delay line: A_DELAY-deep shift register of {valid, a}. It shifts every cycle and has no stall.
  - a_d is a_in from A_DELAY cycles earlier.
  - v_d is the matching delayed valid.
- Stage 1 (registered), on v_d & prod_valid:
  - s = a_d + p_in, 31 bits unsigned.
  - d = a_d - p_in, 31 bits two's complement.
  - v1 <= v_d & prod_valid.
- Stage 2 (registered), when v1:
  - x_out <= (s >= q) ? s - q : s.
  - y_out <= d[30] ? d + q : d, truncated to DW.
  - out_valid <= v1.
- When v1 = 0: out_valid <= 0 and x_out/y_out hold their previous values.
- Latency: in_valid to out_valid = A_DELAY + 2 cycles. prod_valid/p_in to out_valid = 2 cycles.
- Throughput: one butterfly per cycle, back-to-back, order preserved. No backpressure; the consumer must accept every out_valid beat.
- Alignment check: align_err <= 1 on any cycle where v_d != prod_valid.
  - Covers prod_valid high with no delayed a, and delayed a with no product.
  - The mismatched beat is discarded (v1 = 0).
  - align_err stays high until rst_n.
- Out-of-range inputs (>= q) are not checked. The output is defined by the single conditional correction above and is not guaranteed < q.
- Arithmetic is exact; q is held as a DW-bit constant.

Test Plan:
- Q_INDEX=0, A_DELAY=4: a_in=1063321600 at t0, p_in=1 with prod_valid at t0+4 -> out_valid at t0+6, x_out=0, y_out=1063321599.
- Q_INDEX=0: a=0, p=10 -> x_out=10, y_out=1063321591. Then a=5, p=5 -> x_out=10, y_out=0.
- Q_INDEX=12: a=1073479680, p=1073479680 -> x_out=1073479679, y_out=0. Q_INDEX=8: a=90, p=30 -> x_out=120, y_out=60.
- Eight in_valid beats on consecutive cycles with a=1..8, p=100 -> eight consecutive out_valid beats starting A_DELAY+2 after the first, with x=101..108 and y=q0-99..q0-92 (1063321502..1063321509), in order, align_err stays 0.
- prod_valid pulsed with no in_valid A_DELAY earlier -> align_err=1 on the next edge, remains 1 through later valid traffic, no out_valid for that beat.
- Assert rst_n=0 while three butterflies are in flight -> out_valid, x_out, y_out, align_err read 0 immediately, before the next clock edge. After release with no new input, out_valid stays 0 for at least A_DELAY+3 cycles.
